// File: rtl/sha512_pkg.sv
// Shared SHA-512 sizes, types and the padder state encoding; also imported by the compressor.
package sha512_pkg;
    localparam int WORD_BITS       = 64;
    localparam int CHUNK_WORDS     = 16;
    localparam int CHUNK_BITS      = 1024;
    localparam int CHUNK_BYTES     = 128;
    localparam int LEN_FIELD_BYTES = 16;
    localparam int LEN_FIELD_START = 112;
    localparam int COUNT_BITS      = 125;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [WORD_BITS-1:0]  word_t;
    typedef logic [CHUNK_BITS-1:0] chunk_t;

    typedef enum logic [1:0] {
        S_FILL,
        S_OUT,
        S_OUT_EXTRA
    } state_t;

    // Word i of a chunk sits MSB-first, so word 0 occupies the top 64 bits.
    function automatic word_t get_word(chunk_t c, int i);
        return c[CHUNK_BITS-1-WORD_BITS*i -: WORD_BITS];
    endfunction

    function automatic chunk_t put_word(chunk_t c, int i, word_t w);
        chunk_t r;
        r = c;
        r[CHUNK_BITS-1-WORD_BITS*i -: WORD_BITS] = w;
        return r;
    endfunction
endpackage

// File: rtl/sha512_last_word_mask.sv
// Trims the final message word to its valid bytes and appends the 0x80 pad byte;
// spill flags a full word, where the pad byte belongs to the next word position.
module sha512_last_word_mask
    import sha512_pkg::*;
(
    input  word_t      data,
    input  logic [3:0] nbytes,
    output word_t      masked,
    output logic       spill
);
    always_comb begin
        masked = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(nbytes))
                masked[WORD_BITS-1-8*j -: 8] = data[WORD_BITS-1-8*j -: 8];
            else if (j == int'(nbytes))
                masked[WORD_BITS-1-8*j -: 8] = PAD_BYTE;
        end
    end

    assign spill = (nbytes == 4'd8);
endmodule

// File: rtl/sha512_padder.sv
// SHA-512 message padder: packs 64-bit words into 1024-bit chunks, adds the 0x80 byte,
// zero fill and the 128-bit bit length, spilling into an extra chunk when it does not fit.
module sha512_padder
    import sha512_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  word_t        in_data,
    input  logic         in_last,
    input  logic [3:0]   in_nbytes,
    output logic         out_valid,
    input  logic         out_ready,
    output chunk_t       out_chunk,
    output logic         out_last
);
    localparam int LEN_WORD = LEN_FIELD_START / 8;

    state_t                state;
    logic [3:0]            w;
    logic [COUNT_BITS-1:0] cnt;
    chunk_t                acc;
    logic                  extra_pend;
    logic                  extra_pad;

    word_t                 masked;
    logic                  spill;
    logic                  accept;
    logic [COUNT_BITS-1:0] cnt_next;
    logic [127:0]          len_next;
    logic [127:0]          len_cur;
    logic                  fits;
    chunk_t                fill_chunk;
    chunk_t                extra_chunk;

    sha512_last_word_mask u_mask (
        .data   (in_data),
        .nbytes (in_nbytes),
        .masked (masked),
        .spill  (spill)
    );

    assign in_ready = (state == S_FILL) && !reset;
    assign accept   = in_valid && in_ready;
    assign cnt_next = cnt + (in_last ? COUNT_BITS'(in_nbytes) : COUNT_BITS'(8));
    assign len_next = {cnt_next, 3'b000};
    assign len_cur  = {cnt, 3'b000};
    // Pad position p = 8w + nbytes must stay below 112 for the length to share this chunk.
    assign fits     = (w < 4'd13) || (w == 4'd13 && !spill);

    always_comb begin
        fill_chunk = '0;
        for (int k = 0; k < CHUNK_WORDS; k++) begin
            if (k < int'(w))
                fill_chunk = put_word(fill_chunk, k, get_word(acc, k));
            else if (k == int'(w))
                fill_chunk = put_word(fill_chunk, k, in_last ? masked : in_data);
            else if (in_last && spill && k == int'(w) + 1)
                fill_chunk = put_word(fill_chunk, k, {PAD_BYTE, 56'd0});
        end
        if (in_last && fits) begin
            fill_chunk = put_word(fill_chunk, LEN_WORD,     len_next[127:64]);
            fill_chunk = put_word(fill_chunk, LEN_WORD + 1, len_next[63:0]);
        end
    end

    always_comb begin
        extra_chunk = '0;
        if (extra_pad)
            extra_chunk = put_word(extra_chunk, 0, {PAD_BYTE, 56'd0});
        extra_chunk = put_word(extra_chunk, LEN_WORD,     len_cur[127:64]);
        extra_chunk = put_word(extra_chunk, LEN_WORD + 1, len_cur[63:0]);
    end

    // Data-only accumulator; stale slots beyond w are never read.
    always_ff @(posedge clk) begin
        if (accept)
            acc <= put_word(acc, int'(w), in_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FILL;
            w          <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_chunk  <= '0;
            extra_pend <= 1'b0;
            extra_pad  <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        cnt <= cnt_next;
                        if (in_last) begin
                            out_chunk  <= fill_chunk;
                            out_valid  <= 1'b1;
                            out_last   <= fits;
                            extra_pend <= !fits;
                            extra_pad  <= (w == 4'd15) && spill;
                            state      <= S_OUT;
                        end else if (w == 4'd15) begin
                            out_chunk  <= fill_chunk;
                            out_valid  <= 1'b1;
                            out_last   <= 1'b0;
                            extra_pend <= 1'b0;
                            state      <= S_OUT;
                        end else begin
                            w <= w + 4'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (extra_pend) begin
                            out_chunk  <= extra_chunk;
                            out_last   <= 1'b1;
                            extra_pend <= 1'b0;
                            state      <= S_OUT_EXTRA;
                        end else begin
                            out_valid <= 1'b0;
                            w         <= '0;
                            if (out_last)
                                cnt <= '0;
                            state <= S_FILL;
                        end
                    end
                end
                S_OUT_EXTRA: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        w         <= '0;
                        cnt       <= '0;
                        state     <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sha512_padder.sv
// Directed bench for sha512_padder: known padding layouts, two-chunk spills,
// output backpressure and reset in the middle of a message.
module tb_sha512_padder;
    import sha512_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    word_t      in_data = '0;
    logic       in_last = 1'b0;
    logic [3:0] in_nbytes = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    chunk_t     out_chunk;
    logic       out_last;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sha512_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chunk (out_chunk),
        .out_last  (out_last)
    );

    function automatic word_t pat(int i);
        logic [7:0] b;
        b = 8'(i * 17 + 1);
        return {8{b}};
    endfunction

    function automatic word_t wd(chunk_t c, int i);
        return c[1023-64*i -: 64];
    endfunction

    function automatic chunk_t setw(chunk_t c, int i, word_t v);
        chunk_t r;
        r = c;
        r[1023-64*i -: 64] = v;
        return r;
    endfunction

    function automatic int first_diff(chunk_t a, chunk_t b);
        for (int i = 0; i < 16; i++)
            if (wd(a, i) !== wd(b, i)) return i;
        return 0;
    endfunction

    task automatic send_word(input word_t d, input logic last, input logic [3:0] nb);
        int n;
        in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic recv(output chunk_t c, output logic l);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL recv_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
        end
        c = out_chunk; l = out_last;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        n_vec++; if (out_chunk !== '0) begin n_err++; $display("FAIL rst_out_chunk: word%0d got %h want 0", first_diff(out_chunk, '0), wd(out_chunk, first_diff(out_chunk, '0))); end
        reset = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_abc(input string tag);
        chunk_t c, e; logic l; int k;
        e = '0;
        e = setw(e, 0, 64'h6162638000000000);
        e = setw(e, 15, 64'h18);
        send_word(64'h6162630000000000, 1'b1, 4'd3);
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL %s_chunk: word%0d got %h want %h", tag, k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL %s_last: got %b want 1", tag, l); end
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready); end
    endtask

    task automatic test_empty();
        chunk_t c, e; logic l; int k;
        e = '0;
        e = setw(e, 0, 64'h8000000000000000);
        send_word(64'hDEADBEEFCAFEF00D, 1'b1, 4'd0);
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL empty_chunk: word%0d got %h want %h", k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL empty_last: got %b want 1", l); end
    endtask

    task automatic test_111();
        chunk_t c, e; logic l; int k;
        e = '0;
        for (int i = 0; i < 13; i++) begin
            e = setw(e, i, pat(i));
            send_word(pat(i), 1'b0, 4'd8);
        end
        e = setw(e, 13, 64'h0D0D0D0D0D0D0D80);
        e = setw(e, 15, 64'h378);
        send_word(64'h0D0D0D0D0D0D0DFF, 1'b1, 4'd7);
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL b111_chunk: word%0d got %h want %h", k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL b111_last: got %b want 1", l); end
    endtask

    task automatic test_112();
        chunk_t c, e; logic l; int k;
        e = '0;
        for (int i = 0; i < 14; i++) begin
            e = setw(e, i, pat(i));
            send_word(pat(i), i == 13, 4'd8);
        end
        e = setw(e, 14, 64'h8000000000000000);
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL b112_chunk1: word%0d got %h want %h", k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b0) begin n_err++; $display("FAIL b112_last1: got %b want 0", l); end
        n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL b112_back_to_back: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready); end
        e = '0;
        e = setw(e, 15, 64'h380);
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL b112_chunk2: word%0d got %h want %h", k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL b112_last2: got %b want 1", l); end
    endtask

    task automatic test_128();
        chunk_t c, e; logic l; int k;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            e = setw(e, i, pat(i));
            send_word(pat(i), i == 15, 4'd8);
        end
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL b128_chunk1: word%0d got %h want %h", k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b0) begin n_err++; $display("FAIL b128_last1: got %b want 0", l); end
        e = '0;
        e = setw(e, 0, 64'h8000000000000000);
        e = setw(e, 15, 64'h400);
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL b128_chunk2: word%0d got %h want %h", k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL b128_last2: got %b want 1", l); end
    endtask

    task automatic test_backpressure();
        chunk_t c, e; logic l; int k;
        e = '0;
        e = setw(e, 0, 64'h6162638000000000);
        e = setw(e, 15, 64'h18);
        send_word(64'h6162630000000000, 1'b1, 4'd3);
        // Offer a stray word while the chunk is stalled; it must not be taken.
        in_valid = 1'b1; in_data = 64'hFFFFFFFFFFFFFFFF; in_last = 1'b1; in_nbytes = 4'd8;
        for (int cyc = 0; cyc < 5; cyc++) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_c%0d: got %b want 1", cyc, out_valid); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_c%0d: got %b want 0", cyc, in_ready); end
            n_vec++; if (out_last !== 1'b1) begin n_err++; $display("FAIL bp_last_c%0d: got %b want 1", cyc, out_last); end
            n_vec++; if (out_chunk !== e) begin n_err++; k = first_diff(out_chunk, e); $display("FAIL bp_chunk_c%0d: word%0d got %h want %h", cyc, k, wd(out_chunk, k), wd(e, k)); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        recv(c, l);
        n_vec++; if (c !== e) begin n_err++; k = first_diff(c, e); $display("FAIL bp_chunk_final: word%0d got %h want %h", k, wd(c, k), wd(e, k)); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL bp_last_final: got %b want 1", l); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++)
            send_word(pat(i + 3), 1'b0, 4'd8);
        reset = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_state: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        test_abc("mid_rst_abc");
    endtask

    initial begin
        test_reset();
        test_abc("abc");
        test_empty();
        test_111();
        test_112();
        test_128();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
